tms_bus_if: RTL and testbench

//  Host-bus front end for the VDP core on the 27 MHz pixel clock. Synchronises the asynchronous
//  TMS9918-style strobes csr_n/csw_n and filters glitches from them. For each qualified access it

---
 rtl/tms_bus_if.sv | 146 ++++++++++++++
 tb/tb_tms_bus_if.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tms_bus_if.sv
// Host-bus front end for the VDP core. Synchronises and glitch-filters the async
// csr_n/csw_n strobes, then issues exactly one req (with wrt) per qualified access,
// latching the port select into adr and the bit-reversed host data into dbo.
module tms_bus_if #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned QUAL_CYCLES    = 3,
  parameter int unsigned RELEASE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_n,
  input  logic        csw_n,
  input  logic [1:0]  mode,
  input  logic [7:0]  cd_in,
  output logic        req,
  output logic        wrt,
  output logic [15:0] adr,
  output logic [7:0]  dbo,
  output logic        cd_oe,
  output logic        bus_err
);

  localparam int unsigned QW = $clog2(QUAL_CYCLES + 1);
  localparam int unsigned RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [QW-1:0] QualMax = QW'(QUAL_CYCLES);
  localparam logic [RW-1:0] RelMax  = RW'(RELEASE_CYCLES);

  typedef enum logic [2:0] {StIdle, StQual, StIssue, StHold, StRelease} state_e;

  logic [SYNC_STAGES-1:0]      csr_sync_q;
  logic [SYNC_STAGES-1:0]      csw_sync_q;
  logic [SYNC_STAGES-1:0][1:0] mode_sync_q;
  logic [SYNC_STAGES-1:0][7:0] cd_sync_q;

  logic       csr_s, csw_s;
  logic [1:0] mode_s;
  logic [7:0] cd_s;
  logic [7:0] cd_rev;
  logic       active_s;

  state_e        state_q;
  logic [QW-1:0] qcnt_q;
  logic [RW-1:0] rcnt_q;
  logic          is_wr_q;

  assign csr_s  = csr_sync_q[SYNC_STAGES-1];
  assign csw_s  = csw_sync_q[SYNC_STAGES-1];
  assign mode_s = mode_sync_q[SYNC_STAGES-1];
  assign cd_s   = cd_sync_q[SYNC_STAGES-1];
  // Level of the strobe that opened the current access.
  assign active_s = is_wr_q ? csw_s : csr_s;

  // Synchroniser chains; strobes preset inactive so reset never looks like an access.
  always_ff @(posedge clk) begin
    if (reset) begin
      csr_sync_q  <= '1;
      csw_sync_q  <= '1;
      mode_sync_q <= '0;
      cd_sync_q   <= '0;
    end else begin
      csr_sync_q  <= {csr_sync_q[SYNC_STAGES-2:0], csr_n};
      csw_sync_q  <= {csw_sync_q[SYNC_STAGES-2:0], csw_n};
      mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], mode};
      cd_sync_q   <= {cd_sync_q[SYNC_STAGES-2:0], cd_in};
    end
  end

  // TI bit order: host bit 0 is the bus MSB.
  always_comb begin
    cd_rev = '0;
    for (int i = 0; i < 8; i++) cd_rev[i] = cd_s[7-i];
  end

  // Access FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRelease;
      qcnt_q  <= '0;
      rcnt_q  <= '0;
      is_wr_q <= 1'b0;
      req     <= 1'b0;
      wrt     <= 1'b0;
      adr     <= '0;
      dbo     <= '0;
      cd_oe   <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      req     <= 1'b0;
      wrt     <= 1'b0;
      bus_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!csr_s && !csw_s) begin
            bus_err <= 1'b1;
            rcnt_q  <= '0;
            state_q <= StRelease;
          end else if (!csr_s || !csw_s) begin
            is_wr_q <= !csw_s;
            qcnt_q  <= QW'(1);
            state_q <= (QUAL_CYCLES == 1) ? StIssue : StQual;
          end
        end
        StQual: begin
          if (!csr_s && !csw_s) begin
            bus_err <= 1'b1;
            rcnt_q  <= '0;
            state_q <= StRelease;
          end else if (active_s) begin
            state_q <= StIdle;
          end else begin
            if (qcnt_q != QualMax) qcnt_q <= qcnt_q + 1'b1;
            if (qcnt_q >= QualMax - 1'b1) state_q <= StIssue;
          end
        end
        StIssue: begin
          req     <= 1'b1;
          wrt     <= is_wr_q;
          adr     <= {14'b0, mode_s};
          if (is_wr_q) dbo <= cd_rev;
          state_q <= StHold;
        end
        StHold: begin
          // Only the accepted strobe's release ends the access; the other one idles high.
          if (active_s) begin
            cd_oe   <= 1'b0;
            rcnt_q  <= '0;
            state_q <= StRelease;
          end else begin
            cd_oe <= !is_wr_q;
          end
        end
        StRelease: begin
          cd_oe <= 1'b0;
          if (csr_s && csw_s) begin
            if (rcnt_q != RelMax) rcnt_q <= rcnt_q + 1'b1;
            if (rcnt_q >= RelMax - 1'b1) state_q <= StIdle;
          end else begin
            rcnt_q <= '0;
          end
        end
        default: state_q <= StRelease;
      endcase
    end
  end

endmodule

// File: tb/tb_tms_bus_if.sv
// Self-checking bench for tms_bus_if: directed table, reset corner cases,
// randomized accesses against a transaction-level model, and a 100-write burst.
module tb_tms_bus_if;

  localparam int S = 2;
  localparam int Q = 3;
  localparam int R = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_n, csw_n;
  logic [1:0]  mode;
  logic [7:0]  cd_in;
  logic        req, wrt, cd_oe, bus_err;
  logic [15:0] adr;
  logic [7:0]  dbo;

  tms_bus_if #(
    .SYNC_STAGES   (S),
    .QUAL_CYCLES   (Q),
    .RELEASE_CYCLES(R)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .csr_n  (csr_n),
    .csw_n  (csw_n),
    .mode   (mode),
    .cd_in  (cd_in),
    .req    (req),
    .wrt    (wrt),
    .adr    (adr),
    .dbo    (dbo),
    .cd_oe  (cd_oe),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  dbo;
  } req_t;

  req_t req_q[$];
  int   err_cnt = 0;
  int   oe_cnt = 0;
  int   oe_first = 0;
  int   stray = 0;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (req) req_q.push_back('{cyc, wrt, adr, dbo});
    if (!req && wrt) stray++;
    if (bus_err) err_cnt++;
    if (cd_oe) begin
      if (oe_cnt == 0) oe_first = cyc;
      oe_cnt++;
    end
  end

  int tests = 0;
  int fails = 0;

  logic [15:0] model_adr = '0;
  logic [7:0]  model_dbo = '0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] bitrev(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  task automatic clear_mon();
    req_q.delete();
    err_cnt  = 0;
    oe_cnt   = 0;
    oe_first = 0;
    stray    = 0;
  endtask

  // Drive one strobe pulse of w edges, then hold both strobes high for gap edges.
  task automatic run_access(input bit rd, input bit wr, input logic [1:0] m,
                            input logic [7:0] d, input int w, input int gap, output int t0);
    clear_mon();
    mode  = m;
    cd_in = d;
    csr_n = ~rd;
    csw_n = ~wr;
    t0 = cyc + 1;
    repeat (w) tick();
    csr_n = 1'b1;
    csw_n = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic check_access(input string name, input int t0, input bit e_req, input bit e_wrt,
                              input logic [15:0] e_adr, input logic [7:0] e_dbo,
                              input int e_err, input int e_oe);
    check({name, " req count"}, 32'(req_q.size()), e_req ? 32'd1 : 32'd0);
    if (e_req && req_q.size() != 0) begin
      check({name, " req latency"}, 32'(req_q[0].cyc), 32'(t0 + S + Q));
      check({name, " wrt"}, 32'(req_q[0].wrt), 32'(e_wrt));
      check({name, " adr at req"}, 32'(req_q[0].adr), 32'(e_adr));
      check({name, " dbo at req"}, 32'(req_q[0].dbo), 32'(e_dbo));
    end
    check({name, " adr held"}, 32'(adr), 32'(e_adr));
    check({name, " dbo held"}, 32'(dbo), 32'(e_dbo));
    check({name, " bus_err pulses"}, 32'(err_cnt), 32'(e_err));
    check({name, " cd_oe cycles"}, 32'(oe_cnt), 32'(e_oe));
    if (e_oe > 0) check({name, " cd_oe start"}, 32'(oe_first), 32'(t0 + S + Q + 1));
    check({name, " wrt without req"}, 32'(stray), 32'd0);
  endtask

  // Transaction-level model: a lone strobe low for >= Q edges is one access.
  task automatic model_access(input string name, input bit rd, input bit wr,
                              input logic [1:0] m, input logic [7:0] d, input int w, input int t0);
    bit e_req;
    int e_oe;
    e_req = (rd ^ wr) && (w >= Q);
    if (e_req) begin
      model_adr = {14'b0, m};
      if (wr) model_dbo = bitrev(d);
    end
    e_oe = (e_req && rd && w > Q + 1) ? w - Q - 1 : 0;
    check_access(name, t0, e_req, wr, model_adr, model_dbo, (rd && wr) ? 1 : 0, e_oe);
  endtask

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [1:0]  m;
    logic [7:0]  d;
    int          w;
    bit          e_req;
    bit          e_wrt;
    logic [15:0] e_adr;
    logic [7:0]  e_dbo;
    int          e_err;
    int          e_oe;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int t0;

    vecs[0] = '{"write1",     0, 1, 2'b01, 8'h80, 40, 1, 1, 16'h0001, 8'h01, 0, 0};
    vecs[1] = '{"read40",     1, 0, 2'b10, 8'h5A, 40, 1, 0, 16'h0002, 8'h01, 0, 36};
    vecs[2] = '{"glitch2",    0, 1, 2'b11, 8'hFF, 2,  0, 0, 16'h0002, 8'h01, 0, 0};
    vecs[3] = '{"post_glit",  0, 1, 2'b11, 8'h0F, 40, 1, 1, 16'h0003, 8'hF0, 0, 0};
    vecs[4] = '{"collision",  1, 1, 2'b00, 8'hAA, 10, 0, 0, 16'h0003, 8'hF0, 1, 0};
    vecs[5] = '{"post_coll",  0, 1, 2'b00, 8'h06, 40, 1, 1, 16'h0000, 8'h60, 0, 0};
    vecs[6] = '{"read_w3",    1, 0, 2'b01, 8'h33, 3,  1, 0, 16'h0001, 8'h60, 0, 0};
    vecs[7] = '{"read_w5",    1, 0, 2'b10, 8'h44, 5,  1, 0, 16'h0002, 8'h60, 0, 1};
    vecs[8] = '{"write_w3",   0, 1, 2'b01, 8'h01, 3,  1, 1, 16'h0001, 8'h80, 0, 0};
    vecs[9] = '{"glitch1",    1, 0, 2'b11, 8'h00, 1,  0, 0, 16'h0001, 8'h80, 0, 0};

    // Reset with a read strobe already low: must never be issued.
    reset = 1'b1;
    csr_n = 1'b0;
    csw_n = 1'b1;
    mode  = 2'b11;
    cd_in = 8'hA5;
    repeat (3) tick();
    check("reset req", 32'(req), 32'd0);
    check("reset wrt", 32'(wrt), 32'd0);
    check("reset adr", 32'(adr), 32'd0);
    check("reset dbo", 32'(dbo), 32'd0);
    check("reset cd_oe", 32'(cd_oe), 32'd0);
    check("reset bus_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    clear_mon();
    repeat (15) tick();
    check("held-through-reset req", 32'(req_q.size()), 32'd0);
    check("held-through-reset cd_oe", 32'(oe_cnt), 32'd0);
    csr_n = 1'b1;
    repeat (12) tick();

    // Directed table.
    foreach (vecs[i]) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].m, vecs[i].d, vecs[i].w, 12, t0);
      check_access(vecs[i].name, t0, vecs[i].e_req, vecs[i].e_wrt, vecs[i].e_adr,
                   vecs[i].e_dbo, vecs[i].e_err, vecs[i].e_oe);
      model_adr = vecs[i].e_adr;
      model_dbo = vecs[i].e_dbo;
    end

    // Reset during HOLD with csw_n still low.
    clear_mon();
    mode  = 2'b10;
    cd_in = 8'h12;
    csw_n = 1'b0;
    repeat (8) tick();
    check("pre-reset req", 32'(req_q.size()), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset req", 32'(req), 32'd0);
    check("midreset adr", 32'(adr), 32'd0);
    check("midreset dbo", 32'(dbo), 32'd0);
    check("midreset cd_oe", 32'(cd_oe), 32'd0);
    model_adr = '0;
    model_dbo = '0;
    clear_mon();
    repeat (20) tick();
    check("midreset no req while low", 32'(req_q.size()), 32'd0);
    csw_n = 1'b1;
    repeat (3) tick();
    run_access(1'b0, 1'b1, 2'b10, 8'h12, 20, 12, t0);
    model_access("rearm", 1'b0, 1'b1, 2'b10, 8'h12, 20, t0);

    // Randomized single-strobe accesses.
    for (int i = 0; i < 60; i++) begin
      bit          wr;
      logic [1:0]  m;
      logic [7:0]  d;
      int          w;
      wr = 1'($urandom_range(0, 1));
      m  = 2'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      w  = int'($urandom_range(1, 45));
      run_access(~wr, wr, m, d, w, int'($urandom_range(12, 30)), t0);
      model_access("random", ~wr, wr, m, d, w, t0);
    end

    // 100 writes at ~1 us spacing.
    for (int i = 0; i < 100; i++) begin
      run_access(1'b0, 1'b1, 2'($urandom_range(0, 3)), 8'(i), 10, 17, t0);
      model_access("burst", 1'b0, 1'b1, mode, 8'(i), 10, t0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
